// File: rtl/ahb_gpio_param.sv
// ahb_gpio_param: AHB-Lite GPIO with byte-lane parity, direction, input sync and sticky parity errors; define GPIO_EDGE_IRQ_EN for rising-edge IRQs
module ahb_gpio_param #(
  parameter int GPIO_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic                       HSEL,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic                       HREADY,
  output logic                       HREADYOUT,
  input  logic [31:0]                HWDATA,
  output logic [31:0]                HRDATA,
  input  logic [GPIO_W+GPIO_W/8-1:0] GPIOIN,
  output logic [GPIO_W+GPIO_W/8-1:0] GPIOOUT,
  input  logic                       PARITYSEL,
  output logic                       PARITYERR,
  output logic                       IRQ
);
  localparam int NB = GPIO_W / 8;
  localparam int PW = GPIO_W + NB;
  logic               act_q, act_d, wr_q, wr_d, err_q, err_d, perr_q, perr_d, irq_q, irq_d;
  logic               we, edge_irq, unused_bits;
  logic [2:0]         addr_q, addr_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [GPIO_W-1:0]  data_q, data_d, dir_q, dir_d, wd, dout, rval;
  logic [NB-1:0]      pstat_q, pstat_d, lane_err;
  logic [PW-1:0]      sync_q [SYNC_STAGES];
  logic [PW-1:0]      sync_d [SYNC_STAGES];
  logic [PW-1:0]      out_q, out_d, syn;
  logic [GPIO_W+31:0] wext, rext;
`ifdef GPIO_EDGE_IRQ_EN
  logic [GPIO_W-1:0]  irqen_q, irqen_d, irqstat_q, irqstat_d, prev_q, prev_d;
`endif
  assign HREADYOUT = 1'b1;
  assign GPIOOUT = out_q;
  assign PARITYERR = perr_q;
  assign IRQ = irq_q;
  assign syn = sync_q[SYNC_STAGES-1];
  assign we = act_q & wr_q;
  assign wext = {{GPIO_W{1'b0}}, HWDATA};
  assign wd = wext[GPIO_W-1:0];
  assign rext = {32'd0, rval};
  assign HRDATA = (act_q & ~wr_q) ? rext[31:0] : 32'd0;
  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], wext[GPIO_W+31:GPIO_W], rext[GPIO_W+31:32]};
  always_comb begin
    act_d = HSEL & HREADY & HTRANS[1];
    addr_d = HADDR[4:2];
    wr_d = HWRITE;
    data_d = (we && addr_q == 3'd0) ? wd : data_q;
    dir_d = (we && addr_q == 3'd1) ? wd : dir_q;
    ctrl_d = (we && addr_q == 3'd3) ? wd[1:0] : ctrl_q;
    dout = data_q & dir_q;
    out_d = {{NB{1'b0}}, dout};
    lane_err = '0;
    for (int l = 0; l < NB; l++) begin
      out_d[GPIO_W+l] = ^dout[8*l+:8] ^ PARITYSEL;
      lane_err[l] = ctrl_q[0] & ((^{syn[GPIO_W+l], syn[8*l+:8]}) != PARITYSEL);
    end
    pstat_d = (pstat_q & ~((we && addr_q == 3'd4) ? wd[NB-1:0] : '0)) | lane_err;
    err_d = |lane_err;
    perr_d = err_q;
    irq_d = edge_irq | (ctrl_q[1] & |pstat_q);
    sync_d[0] = GPIOIN;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end
  always_comb begin
    rval = '0;
    case (addr_q)
      3'd0: rval = data_q;
      3'd1: rval = dir_q;
      3'd2: rval = syn[GPIO_W-1:0];
      3'd3: rval = {{(GPIO_W-2){1'b0}}, ctrl_q};
      3'd4: rval = {{(GPIO_W-NB){1'b0}}, pstat_q};
`ifdef GPIO_EDGE_IRQ_EN
      3'd5: rval = irqen_q;
      3'd6: rval = irqstat_q;
`endif
      default: rval = '0;
    endcase
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      act_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      dir_q <= '0;
      ctrl_q <= '0;
      pstat_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
      perr_q <= 1'b0;
      irq_q <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      act_q <= act_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      dir_q <= dir_d;
      ctrl_q <= ctrl_d;
      pstat_q <= pstat_d;
      out_q <= out_d;
      err_q <= err_d;
      perr_q <= perr_d;
      irq_q <= irq_d;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
    end
  end
`ifdef GPIO_EDGE_IRQ_EN
  always_comb begin
    irqen_d = (we && addr_q == 3'd5) ? wd : irqen_q;
    irqstat_d = (irqstat_q & ~((we && addr_q == 3'd6) ? wd : '0)) | (syn[GPIO_W-1:0] & ~prev_q & ~dir_q);
    prev_d = syn[GPIO_W-1:0];
    edge_irq = |(irqstat_q & irqen_q);
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irqen_q <= '0;
      irqstat_q <= '0;
      prev_q <= '0;
    end else begin
      irqen_q <= irqen_d;
      irqstat_q <= irqstat_d;
      prev_q <= prev_d;
    end
  end
`else
  assign edge_irq = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_gpio_param.sv
// tb_ahb_gpio_param: scoreboard bench for ahb_gpio_param against a register-level reference model
module tb_ahb_gpio_param;
  localparam int W = 16;
  localparam int NB = 2;
  localparam int PW = 18;
  typedef struct {
    bit          pin;
    string       name;
    logic [31:0] exp;
  } item_t;
  logic          HCLK = 0, HRESET = 1, HSEL = 0, HWRITE = 0, HREADY = 1, PARITYSEL = 0;
  logic [31:0]   HADDR = 0, HWDATA = 0;
  logic [1:0]    HTRANS = 0;
  logic          HREADYOUT, PARITYERR, IRQ;
  logic [31:0]   HRDATA;
  logic [PW-1:0] GPIOIN = 0, GPIOOUT;
  item_t         q[$];
  int            n_chk = 0, n_pass = 0, perr_seen = 0;
  logic          pin_req = 0, mon_rd, mon_pin, cnt_en = 0;
  logic [W-1:0]  m_data = 0, m_dir = 0, m_in = 0, m_irqen = 0, m_irqstat = 0;
  logic [1:0]    m_ctrl = 0;
  logic [NB-1:0] m_pstat = 0;
  logic [PW-1:0] v;
  ahb_gpio_param #(.GPIO_W(W), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .GPIOIN(GPIOIN), .GPIOOUT(GPIOOUT), .PARITYSEL(PARITYSEL),
    .PARITYERR(PARITYERR), .IRQ(IRQ)
  );
  always #5 HCLK = ~HCLK;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [PW-1:0] m_out();
    logic [W-1:0] d = m_data & m_dir;
    logic [PW-1:0] r = PW'(d);
    for (int l = 0; l < NB; l++) r[W+l] = ($countones(d[8*l+:8]) % 2 == 1) ^ PARITYSEL;
    return r;
  endfunction
  function automatic logic [NB-1:0] bad(logic [PW-1:0] x);
    logic [NB-1:0] b = '0;
    for (int l = 0; l < NB; l++) b[l] = (($countones(x[8*l+:8]) + int'(x[W+l])) % 2) != int'(PARITYSEL);
    return b;
  endfunction
  function automatic logic m_irq();
    return (|(m_irqstat & m_irqen)) | (m_ctrl[1] & |m_pstat);
  endfunction
  function automatic logic [31:0] pins(logic perr);
    return {11'b0, 1'b1, m_irq(), perr, m_out()};
  endfunction
  function automatic logic [31:0] m_rd(int a);
    case (a)
      0: return 32'(m_data);
      1: return 32'(m_dir);
      2: return 32'(m_in);
      3: return 32'(m_ctrl);
      4: return 32'(m_pstat);
`ifdef GPIO_EDGE_IRQ_EN
      5: return 32'(m_irqen);
      6: return 32'(m_irqstat);
`endif
      default: return 32'd0;
    endcase
  endfunction
  task automatic idle(int n);
    repeat (n) @(negedge HCLK);
  endtask
  task automatic wr(int a, logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1;
    HADDR = ($urandom & 32'hFFFF_FFE3) | (32'(a) << 2);
    @(negedge HCLK);
    HSEL = 0; HTRANS = 0; HWRITE = 0; HWDATA = d;
    case (a)
      0: m_data = d[W-1:0];
      1: m_dir = d[W-1:0];
      3: m_ctrl = d[1:0];
      4: m_pstat = (m_pstat & ~d[NB-1:0]) | (m_ctrl[0] ? bad(GPIOIN) : '0);
`ifdef GPIO_EDGE_IRQ_EN
      5: m_irqen = d[W-1:0];
      6: m_irqstat = m_irqstat & ~d[W-1:0];
`endif
      default: ;
    endcase
  endtask
  task automatic rd(int a, string name);
    item_t it;
    it.pin = 0; it.name = name; it.exp = m_rd(a);
    q.push_back(it);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0;
    HADDR = ($urandom & 32'hFFFF_FFE3) | (32'(a) << 2);
    @(negedge HCLK);
    HSEL = 0; HTRANS = 0;
  endtask
  task automatic pin_chk(string name, logic [31:0] exp);
    item_t it;
    it.pin = 1; it.name = name; it.exp = exp;
    q.push_back(it);
    pin_req = 1;
    @(negedge HCLK);
    pin_req = 0;
  endtask
  task automatic pop_cmp(bit pin);
    item_t it;
    if (q.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard-empty: output seen with no expectation queued");
      return;
    end
    it = q.pop_front();
    if (it.pin != pin) begin
      n_chk++;
      $display("FAIL %s: order got kind %0d expected kind %0d", it.name, pin, it.pin);
    end else chk(it.name, pin ? {11'b0, HREADYOUT, IRQ, PARITYERR, GPIOOUT} : HRDATA, it.exp);
  endtask
  initial forever begin
    @(posedge HCLK);
    mon_rd = HSEL & HREADY & HTRANS[1] & ~HWRITE;
    mon_pin = pin_req;
    if (mon_rd || mon_pin) begin
      @(negedge HCLK);
      if (mon_rd) pop_cmp(0);
      if (mon_pin) pop_cmp(1);
    end
  end
  always @(negedge HCLK) if (cnt_en && PARITYERR) perr_seen++;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    idle(3);
    pin_chk("reset-pins", 32'h0010_0000);
    HRESET = 0;
    for (int a = 0; a < 8; a++) rd(a, $sformatf("reset-reg%0d", a));
    wr(1, 32'hFFFF);
    wr(0, 32'h00A5);
    pin_chk("wr-lat-old", 32'h0010_0000);
    pin_chk("wr-lat-new", 32'h0010_00A5);
    PARITYSEL = 1;
    pin_chk("odd-parity", 32'h0013_00A5);
    PARITYSEL = 0;
    wr(1, 32'h00FF);
    wr(0, 32'hFFFF);
    idle(2);
    pin_chk("dir-mask", 32'h0010_00FF);
    rd(0, "rd-data");
    wr(7, 32'hFFFF_FFFF);
    rd(7, "rd-reserved");
    wr(0, 32'h1234);
    rd(0, "wr-rd-b2b");
    wr(0, 32'hDEAD_BEEF);
    rd(0, "rd-upper");
    for (int i = 0; i < 16; i++) begin
      PARITYSEL = 1'($urandom);
      wr(1, $urandom);
      wr(0, $urandom);
      idle(2);
      pin_chk($sformatf("rand-out%0d", i), pins(0));
      rd($urandom_range(1, 0), $sformatf("rand-rd%0d", i));
    end
    PARITYSEL = 0;
    wr(3, 1);
    GPIOIN = 0;
    idle(4);
    GPIOIN = 18'h3_0001;
    pin_chk("perr-c1", pins(0));
    pin_chk("perr-c2", pins(0));
    pin_chk("perr-c3", pins(0));
    m_pstat = m_pstat | 2'b10;
    m_in = 16'h0001;
    pin_chk("perr-c4", pins(1));
    pin_chk("perr-hold", pins(1));
    rd(4, "pstat-set");
    rd(2, "in-val");
    GPIOIN = 0;
    idle(2);
    pin_chk("perr-tail", pins(1));
    pin_chk("perr-gone", pins(0));
    m_in = 0;
    wr(4, 2);
    rd(4, "pstat-w1c");
    wr(3, 3);
    GPIOIN = 18'h3_0001;
    pin_chk("irq-c1", pins(0));
    pin_chk("irq-c2", pins(0));
    pin_chk("irq-c3", pins(0));
    m_pstat = m_pstat | 2'b10;
    pin_chk("irq-c4", pins(1));
    wr(4, 2);
    idle(2);
    pin_chk("w1c-vs-set-pins", pins(1));
    rd(4, "w1c-vs-set");
    for (int i = 0; i < 8; i++) begin
      PARITYSEL = 1'($urandom);
      v = PW'($urandom);
      GPIOIN = v;
      idle(5);
      m_pstat = m_pstat | bad(v);
      m_in = v[W-1:0];
      pin_chk($sformatf("rpar-pins%0d", i), pins(|bad(v)));
      rd(4, $sformatf("rpar-pstat%0d", i));
      rd(2, $sformatf("rpar-in%0d", i));
      wr(4, 3);
    end
    PARITYSEL = 0;
    GPIOIN = 0;
    m_in = 0;
    idle(5);
    wr(4, 3);
    wr(3, 0);
    idle(2);
    pin_chk("irq-clear", pins(0));
    cnt_en = 1;
    for (int i = 0; i < 24; i++) begin
      m_in = GPIOIN[W-1:0];
      GPIOIN = PW'($urandom);
      rd(2, $sformatf("in-track%0d", i));
    end
    idle(4);
    cnt_en = 0;
    chk("perr-disabled", 32'(perr_seen), 0);
    rd(4, "pstat-disabled");
    wr(1, 0);
`ifdef GPIO_EDGE_IRQ_EN
    wr(5, 1);
    GPIOIN = 0;
    idle(4);
    wr(6, 32'hFFFF);
    idle(1);
    rd(6, "irqstat-clr");
    pin_chk("edge-idle", pins(0));
    GPIOIN = 18'h0_0001;
    pin_chk("edge-c1", pins(0));
    pin_chk("edge-c2", pins(0));
    pin_chk("edge-c3", pins(0));
    m_irqstat = 1;
    pin_chk("edge-c4", pins(0));
    rd(6, "irqstat-set");
    GPIOIN = 0;
    idle(4);
    GPIOIN = 18'h0_0001;
    idle(1);
    wr(6, 1);
    m_irqstat = 1;
    rd(6, "edge-w1c-conflict");
    idle(2);
    wr(6, 1);
    rd(6, "edge-w1c");
    wr(1, 2);
    GPIOIN = 18'h0_0002;
    idle(5);
    rd(6, "edge-dir-out");
`else
    wr(5, 32'hFFFF);
    wr(6, 32'hFFFF);
    rd(5, "noedge-irqen");
    rd(6, "noedge-irqstat");
`endif
    wr(1, 32'hFFFF);
    wr(0, 32'h5A5A);
    GPIOIN = 0;
    idle(5);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 0;
    @(negedge HCLK);
    HSEL = 0; HTRANS = 0; HWRITE = 0; HWDATA = 32'hFFFF; HRESET = 1;
    pin_chk("rst-mid-pins", 32'h0010_0000);
    HRESET = 0;
    m_data = 0; m_dir = 0; m_ctrl = 0; m_pstat = 0; m_irqen = 0; m_irqstat = 0; m_in = 0;
    rd(0, "rst-mid-data");
    rd(1, "rst-mid-dir");
    pin_chk("post-rst-pins", pins(0));
    idle(3);
    chk("scoreboard-drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
